// File: rtl/wsc_pkg.sv
// Shared types and default geometry for the 3x3 window scan controller.
package wsc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOAD,
        SCAN,
        DRAIN,
        DONE
    } state_e;

    localparam int N_C_DEF     = 28;
    localparam int N_R_DEF     = 28;
    localparam int K_DEF       = 3;
    localparam int WIN_PER_ROW = N_C_DEF - K_DEF + 1;
    localparam int WIN_PER_COL = N_R_DEF - K_DEF + 1;
    localparam int WIN_TOTAL   = WIN_PER_ROW * WIN_PER_COL;

    function automatic int win_count(input int nc, input int nr, input int k);
        return (nc - k + 1) * (nr - k + 1);
    endfunction

endpackage

// File: rtl/wsc_counter2d.sv
// Raster-order row/column counter for window top-left addresses.
module wsc_counter2d #(
    parameter int N_C    = 28,
    parameter int N_R    = 28,
    parameter int K      = 3,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              clear_i,
    output logic [ADDR_W-1:0] row_o,
    output logic [ADDR_W-1:0] col_o,
    output logic              col_wrap_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(N_C - K);
    localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(N_R - K);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;

    assign col_wrap_o = (col_q == COL_MAX);
    assign last_o     = col_wrap_o && (row_q == ROW_MAX);
    assign row_o      = row_q;
    assign col_o      = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_wrap_o) begin
                col_d = '0;
                // Final window wraps both axes so the next scan starts at (0,0).
                row_d = last_o ? '0 : row_q + ADDR_W'(1);
            end else begin
                col_d = col_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/window_scan_ctrl.sv
// Sliding 3x3 window scan controller: FSM, read enable and 1-cycle-latency window strobes.
// Optional abort input is compiled in with WSC_ABORT_EN.
module window_scan_ctrl
    import wsc_pkg::*;
#(
    parameter int N_C    = N_C_DEF,
    parameter int N_R    = N_R_DEF,
    parameter int K      = K_DEF,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
`ifdef WSC_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic              mem_full,
    input  logic              win_ready,
    output logic              ren,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic              win_valid,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    state_e state_q, state_d;
    logic   abort_w;
    logic   cnt_clear;
    logic   cnt_last;
    logic   cnt_col_wrap;
    logic   win_valid_q;
    logic   win_last_q;

`ifdef WSC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign ren       = (state_q == SCAN) && win_ready && !abort_w;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    // Counter sits at (0,0) whenever not scanning, so SCAN always enters at origin.
    assign cnt_clear = (state_q != SCAN) || abort_w;

    wsc_counter2d #(
        .N_C    (N_C),
        .N_R    (N_R),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (ren),
        .clear_i    (cnt_clear),
        .row_o      (addr1),
        .col_o      (addr2),
        .col_wrap_o (cnt_col_wrap),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start)            state_d = WAIT_LOAD;
            WAIT_LOAD: if (mem_full)         state_d = SCAN;
            SCAN:      if (ren && cnt_last)  state_d = DRAIN;
            DRAIN:                           state_d = DONE;
            DONE:                            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
        if (abort_w) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= ren;
            win_last_q  <= ren && cnt_last;
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: cycle-vector table plus full-scan sequences.
module tb_window_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mem_full = 1'b0;
    logic       win_ready = 1'b0;
`ifdef WSC_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       ren, win_valid, win_last, busy, done;
    logic [9:0] addr1, addr2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    window_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
`ifdef WSC_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .mem_full  (mem_full),
        .win_ready (win_ready),
        .ren       (ren),
        .addr1     (addr1),
        .addr2     (addr2),
        .win_valid (win_valid),
        .win_last  (win_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " ren"}, 32'(ren), 0);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " win_valid"}, 32'(win_valid), 0);
        chk({nm, " win_last"}, 32'(win_last), 0);
        chk({nm, " done"}, 32'(done), 0);
        chk({nm, " addr1"}, 32'(addr1), 0);
        chk({nm, " addr2"}, 32'(addr2), 0);
    endtask

    typedef struct {
        logic st, mf, wr;
        logic busy, ren, wv, wl, dn;
        int   a1, a2;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic mf, input logic wr,
                                input logic b, input logic r, input logic wv,
                                input int a1, input int a2);
        vec_t v;
        v.st = st; v.mf = mf; v.wr = wr;
        v.busy = b; v.ren = r; v.wv = wv; v.wl = 1'b0; v.dn = 1'b0;
        v.a1 = a1; v.a2 = a2;
        return v;
    endfunction

    // mode 0: all high; 1: random win_ready; 2: start/mem_full disturbed in SCAN;
    // 3: mem_full held low for 50 cycles. exp_done < 0 skips the latency check.
    task automatic scan(input int mode, input int rst_at, input int abort_at,
                        input int exp_done, output int nwin);
        int  er, ec, nlast;
        bit  prev_ren, prev_fin, fin, fin_now;
        er = 0; ec = 0; nlast = 0; nwin = 0;
        prev_ren = 0; prev_fin = 0; fin = 0;
        for (int k = 0; k < 6000 && !fin; k++) begin
            @(negedge clk);
            start     = (k == 0) || (mode == 2 && (k == 100 || k == 101 || k == 400));
            mem_full  = (mode == 3) ? (k > 50) : ((mode == 2) ? (k < 10) : 1'b1);
            win_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("win_valid lag", 32'(win_valid), 32'(prev_ren));
            chk("win_last lag", 32'(win_last), 32'(prev_fin));
            chk("addr1 raster", 32'(addr1), 32'(er));
            chk("addr2 raster", 32'(addr2), 32'(ec));
            if (ren && !win_ready) chk("ren without win_ready", 32'(ren), 0);
            if (mode == 3 && k >= 1 && k <= 50) chk("ren in WAIT_LOAD", 32'(ren), 0);
            if (win_valid) nwin++;
            if (win_last) nlast++;
            fin_now = (er == 25) && (ec == 25);
            if (ren) begin
                if (ec == 25) begin
                    ec = 0;
                    er = (er == 25) ? 0 : er + 1;
                end else begin
                    ec = ec + 1;
                end
            end
            prev_ren = ren;
            prev_fin = ren && fin_now;
            if (done) begin
                chk("window count", 32'(nwin), 676);
                chk("win_last count", 32'(nlast), 1);
                if (exp_done >= 0) chk("start-to-done cycles", 32'(k), 32'(exp_done));
                @(negedge clk);
                start = 1'b0;
                #1;
                chk_idle("after done");
                fin = 1;
            end else begin
                if (k >= 1) chk("busy in scan", 32'(busy), 1);
                if (rst_at > 0 && nwin == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk_idle("rst mid-scan");
                    repeat (3) begin
                        @(negedge clk);
                        start = 1'b0;
                        #1;
                        chk("done under rst", 32'(done), 0);
                    end
                    rst = 1'b0;
                    @(negedge clk);
                    #1;
                    chk_idle("after rst release");
                    fin = 1;
                end
`ifdef WSC_ABORT_EN
                if (!fin && abort_at > 0 && nwin == abort_at) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    start = 1'b0;
                    #1;
                    chk_idle("after abort");
                    abort = 1'b1;
                    start = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    start = 1'b0;
                    #1;
                    chk_idle("abort beats start");
                    fin = 1;
                end
`endif
            end
        end
        if (!fin) chk("scan timeout", 1, 0);
        if (abort_at < 0) chk("abort arg", 0, 1);
    endtask

    vec_t vt[12];
    int   n;

    initial begin
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0);
        vt[2]  = mk(1, 0, 1, 0, 0, 0, 0, 0);
        vt[3]  = mk(0, 0, 1, 1, 0, 0, 0, 0);
        vt[4]  = mk(1, 0, 1, 1, 0, 0, 0, 0);
        vt[5]  = mk(0, 1, 0, 1, 0, 0, 0, 0);
        vt[6]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
        vt[7]  = mk(0, 0, 1, 1, 1, 0, 0, 0);
        vt[8]  = mk(0, 0, 1, 1, 1, 1, 0, 1);
        vt[9]  = mk(0, 0, 0, 1, 0, 1, 0, 2);
        vt[10] = mk(0, 0, 1, 1, 1, 0, 0, 2);
        vt[11] = mk(0, 0, 1, 1, 1, 1, 0, 3);

        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset state");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start     = vt[i].st;
            mem_full  = vt[i].mf;
            win_ready = vt[i].wr;
            #1;
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].busy));
            chk($sformatf("v%0d ren", i), 32'(ren), 32'(vt[i].ren));
            chk($sformatf("v%0d win_valid", i), 32'(win_valid), 32'(vt[i].wv));
            chk($sformatf("v%0d win_last", i), 32'(win_last), 32'(vt[i].wl));
            chk($sformatf("v%0d done", i), 32'(done), 32'(vt[i].dn));
            chk($sformatf("v%0d addr1", i), 32'(addr1), 32'(vt[i].a1));
            chk($sformatf("v%0d addr2", i), 32'(addr2), 32'(vt[i].a2));
        end

        rst = 1'b1;
        #1;
        chk_idle("async rst after table");
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;

        scan(0, 0, 0, 679, n);
        scan(3, 0, 0, 729, n);
        scan(1, 0, 0, -1, n);
        scan(2, 0, 0, 679, n);
        scan(0, 300, 0, -1, n);
        chk("windows before rst", 32'(n), 300);
        scan(0, 0, 0, 679, n);
`ifdef WSC_ABORT_EN
        scan(0, 0, 100, -1, n);
        chk("windows before abort", 32'(n), 100);
        scan(0, 0, 0, 679, n);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
